// File: rtl/pkt_write_tse_if.sv
// rtl/pkt_write_tse_if.sv - packet-word, buffer-id and buffer-RAM signal bundle of pkt_write_tse
interface pkt_write_tse_if;
    logic         i_pkt_wr;
    logic [133:0] iv_pkt;
    logic         o_bufid_req;
    logic         i_pkt_bufid_wr;
    logic [8:0]   iv_pkt_bufid;
    logic         o_mem_wr;
    logic [15:0]  ov_mem_addr;
    logic [133:0] ov_mem_data;
    logic         o_pkt_done;
    logic [8:0]   ov_done_bufid;
    logic [7:0]   ov_done_lines;
    logic         o_bufid_release;
    logic [8:0]   ov_release_bufid;
    logic [15:0]  ov_pkt_cnt;
    logic [15:0]  ov_drop_cnt;
    logic [1:0]   ov_write_state;

    modport slave (
        input  i_pkt_wr, iv_pkt, i_pkt_bufid_wr, iv_pkt_bufid,
        output o_bufid_req, o_mem_wr, ov_mem_addr, ov_mem_data,
        output o_pkt_done, ov_done_bufid, ov_done_lines,
        output o_bufid_release, ov_release_bufid,
        output ov_pkt_cnt, ov_drop_cnt, ov_write_state
    );

    modport master (
        output i_pkt_wr, iv_pkt, i_pkt_bufid_wr, iv_pkt_bufid,
        input  o_bufid_req, o_mem_wr, ov_mem_addr, ov_mem_data,
        input  o_pkt_done, ov_done_bufid, ov_done_lines,
        input  o_bufid_release, ov_release_bufid,
        input  ov_pkt_cnt, ov_drop_cnt, ov_write_state
    );
endinterface

// File: rtl/pkt_write_tse.sv
// rtl/pkt_write_tse.sv - writes 134-bit packet words into the packet buffer under a prefetched buffer id
module pkt_write_tse (
    input  logic            i_clk,
    input  logic            i_rst,
    pkt_write_tse_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         valid_q, valid_d;
    logic [8:0]   bufid_q, bufid_d;
    logic [7:0]   line_q, line_d;
    logic         bufid_req_q, bufid_req_d;
    logic         mem_wr_q, mem_wr_d;
    logic [15:0]  mem_addr_q, mem_addr_d;
    logic [133:0] mem_data_q, mem_data_d;
    logic         pkt_done_q, pkt_done_d;
    logic [8:0]   done_bufid_q, done_bufid_d;
    logic [7:0]   done_lines_q, done_lines_d;
    logic         release_q, release_d;
    logic [8:0]   release_bufid_q, release_bufid_d;
    logic [15:0]  pkt_cnt_q, pkt_cnt_d;
    logic [15:0]  drop_cnt_q, drop_cnt_d;

    logic [1:0]   word_type;
    logic         is_head;
    logic         is_end;
    logic         clr_valid;

    // bit 0 of the type field marks a packet start, bit 1 a packet end
    assign word_type = bus.iv_pkt[133:132];
    assign is_head   = word_type[0];
    assign is_end    = word_type[1];

    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        mem_wr_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;
        pkt_done_d      = 1'b0;
        done_bufid_d    = done_bufid_q;
        done_lines_d    = done_lines_q;
        release_d       = 1'b0;
        release_bufid_d = release_bufid_q;
        pkt_cnt_d       = pkt_cnt_q;
        drop_cnt_d      = drop_cnt_q;
        clr_valid       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_pkt_wr && is_head) begin
                    if (valid_q) begin
                        mem_wr_d   = 1'b1;
                        mem_addr_d = {bufid_q, 7'd0};
                        mem_data_d = bus.iv_pkt;
                        if (is_end) begin
                            pkt_done_d   = 1'b1;
                            done_bufid_d = bufid_q;
                            done_lines_d = 8'd1;
                            clr_valid    = 1'b1;
                            pkt_cnt_d    = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
                        end else begin
                            line_d  = 8'd1;
                            state_d = ST_WRITE;
                        end
                    end else begin
                        drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                        if (!is_end) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (bus.i_pkt_wr) begin
                    // overlength (line 128 reached) and a missing tail both abort the held buffer
                    if (line_q[7] || is_head) begin
                        release_d       = 1'b1;
                        release_bufid_d = bufid_q;
                        clr_valid       = 1'b1;
                        drop_cnt_d      = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                        state_d         = is_end ? ST_IDLE : ST_DROP;
                    end else begin
                        mem_wr_d   = 1'b1;
                        mem_addr_d = {bufid_q, line_q[6:0]};
                        mem_data_d = bus.iv_pkt;
                        if (is_end) begin
                            pkt_done_d   = 1'b1;
                            done_bufid_d = bufid_q;
                            done_lines_d = line_q + 8'd1;
                            clr_valid    = 1'b1;
                            pkt_cnt_d    = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
                            state_d      = ST_IDLE;
                        end else begin
                            line_d = line_q + 8'd1;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (bus.i_pkt_wr && is_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // release of the current id takes effect before a same-cycle delivery is considered
        valid_d = valid_q && !clr_valid;
        bufid_d = bufid_q;
        if (bus.i_pkt_bufid_wr && !valid_d) begin
            valid_d = 1'b1;
            bufid_d = bus.iv_pkt_bufid;
        end
        bufid_req_d = !valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= ST_IDLE;
            valid_q         <= 1'b0;
            bufid_q         <= 9'd0;
            line_q          <= 8'd0;
            bufid_req_q     <= 1'b0;
            mem_wr_q        <= 1'b0;
            mem_addr_q      <= 16'd0;
            mem_data_q      <= 134'd0;
            pkt_done_q      <= 1'b0;
            done_bufid_q    <= 9'd0;
            done_lines_q    <= 8'd0;
            release_q       <= 1'b0;
            release_bufid_q <= 9'd0;
            pkt_cnt_q       <= 16'd0;
            drop_cnt_q      <= 16'd0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            bufid_q         <= bufid_d;
            line_q          <= line_d;
            bufid_req_q     <= bufid_req_d;
            mem_wr_q        <= mem_wr_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            pkt_done_q      <= pkt_done_d;
            done_bufid_q    <= done_bufid_d;
            done_lines_q    <= done_lines_d;
            release_q       <= release_d;
            release_bufid_q <= release_bufid_d;
            pkt_cnt_q       <= pkt_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    assign bus.o_bufid_req      = bufid_req_q;
    assign bus.o_mem_wr         = mem_wr_q;
    assign bus.ov_mem_addr      = mem_addr_q;
    assign bus.ov_mem_data      = mem_data_q;
    assign bus.o_pkt_done       = pkt_done_q;
    assign bus.ov_done_bufid    = done_bufid_q;
    assign bus.ov_done_lines    = done_lines_q;
    assign bus.o_bufid_release  = release_q;
    assign bus.ov_release_bufid = release_bufid_q;
    assign bus.ov_pkt_cnt       = pkt_cnt_q;
    assign bus.ov_drop_cnt      = drop_cnt_q;
    assign bus.ov_write_state   = state_q;
endmodule

// File: tb/tb_pkt_write_tse.sv
// tb/tb_pkt_write_tse.sv - directed self-checking bench for pkt_write_tse
module tb_pkt_write_tse;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    pkt_write_tse_if bus ();

    pkt_write_tse dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] HD = 2'b01, BD = 2'b00, TL = 2'b10, HT = 2'b11;

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] pw(input logic [1:0] t, input int idx);
        logic [31:0] d;
        d = 32'hC0DE_0000 + 32'(idx);
        return {t, 4'hF, d, ~d, d ^ 32'h5A5A_5A5A, d + 32'd7};
    endfunction

    // one clock with the given inputs; on return the outputs reflect that clock
    task automatic step(input logic wr, input logic [133:0] pkt, input logic bwr, input logic [8:0] bid);
        bus.i_pkt_wr       = wr;
        bus.iv_pkt         = pkt;
        bus.i_pkt_bufid_wr = bwr;
        bus.iv_pkt_bufid   = bid;
        @(posedge clk);
        #1;
        bus.i_pkt_wr       = 1'b0;
        bus.i_pkt_bufid_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 9'd0);
        step(1'b0, '0, 1'b0, 9'd0);
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 9'd0);
    endtask

    task automatic wr_word(input logic [1:0] t, input int idx);
        step(1'b1, pw(t, idx), 1'b0, 9'd0);
    endtask

    task automatic give_id(input logic [8:0] bid);
        step(1'b0, '0, 1'b1, bid);
    endtask

    initial begin
        bus.i_pkt_wr       = 1'b0;
        bus.iv_pkt         = '0;
        bus.i_pkt_bufid_wr = 1'b0;
        bus.iv_pkt_bufid   = '0;

        // reset values
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 9'd0);
        step(1'b0, '0, 1'b0, 9'd0);
        check("rst_req", bus.o_bufid_req, 0);
        check("rst_wr", bus.o_mem_wr, 0);
        check("rst_state", bus.ov_write_state, 0);
        check("rst_pkt", bus.ov_pkt_cnt, 0);
        check("rst_drop", bus.ov_drop_cnt, 0);
        check("rst_addr", bus.ov_mem_addr, 0);
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 9'd0);
        check("post_rst_req", bus.o_bufid_req, 1);

        // 3-word packet into buffer 0x1A2
        give_id(9'h1A2);
        check("p1_req0", bus.o_bufid_req, 0);
        wr_word(HD, 1);
        check("p1_wr0", bus.o_mem_wr, 1);
        check("p1_addr0", bus.ov_mem_addr, 16'hD100);
        check("p1_data0", bus.ov_mem_data, pw(HD, 1));
        check("p1_st0", bus.ov_write_state, 1);
        wr_word(BD, 2);
        check("p1_addr1", bus.ov_mem_addr, 16'hD101);
        check("p1_done1", bus.o_pkt_done, 0);
        wr_word(TL, 3);
        check("p1_wr2", bus.o_mem_wr, 1);
        check("p1_addr2", bus.ov_mem_addr, 16'hD102);
        check("p1_data2", bus.ov_mem_data, pw(TL, 3));
        check("p1_done", bus.o_pkt_done, 1);
        check("p1_dbuf", bus.ov_done_bufid, 9'h1A2);
        check("p1_dlines", bus.ov_done_lines, 3);
        check("p1_pkt", bus.ov_pkt_cnt, 1);
        check("p1_req1", bus.o_bufid_req, 1);
        check("p1_st_idle", bus.ov_write_state, 0);
        step(1'b0, '0, 1'b0, 9'd0);
        check("p1_done_pulse", bus.o_pkt_done, 0);
        check("p1_wr_pulse", bus.o_mem_wr, 0);
        check("p1_dbuf_hold", bus.ov_done_bufid, 9'h1A2);

        // no id held: packet dropped
        do_reset();
        wr_word(HD, 10);
        check("nd_wr0", bus.o_mem_wr, 0);
        check("nd_drop", bus.ov_drop_cnt, 1);
        check("nd_st0", bus.ov_write_state, 2);
        wr_word(BD, 11);
        check("nd_wr1", bus.o_mem_wr, 0);
        check("nd_st1", bus.ov_write_state, 2);
        wr_word(TL, 12);
        check("nd_wr2", bus.o_mem_wr, 0);
        check("nd_st2", bus.ov_write_state, 0);
        check("nd_drop2", bus.ov_drop_cnt, 1);
        wr_word(BD, 13);
        wr_word(TL, 14);
        check("idle_body_drop", bus.ov_drop_cnt, 1);
        check("idle_body_st", bus.ov_write_state, 0);
        wr_word(HT, 15);
        check("ht_nid_drop", bus.ov_drop_cnt, 2);
        check("ht_nid_st", bus.ov_write_state, 0);
        check("ht_nid_wr", bus.o_mem_wr, 0);

        // overlength packet on buffer 0x005
        do_reset();
        give_id(9'h005);
        wr_word(HD, 0);
        check("ol_addr0", bus.ov_mem_addr, 16'h0280);
        for (int i = 1; i < 128; i++) begin
            wr_word(BD, i);
            check("ol_wr", bus.o_mem_wr, 1);
            check("ol_addr", bus.ov_mem_addr, 16'h0280 + 16'(i));
        end
        check("ol_st", bus.ov_write_state, 1);
        wr_word(BD, 128);
        check("ol_nowr", bus.o_mem_wr, 0);
        check("ol_rel", bus.o_bufid_release, 1);
        check("ol_relid", bus.ov_release_bufid, 9'h005);
        check("ol_drop", bus.ov_drop_cnt, 1);
        check("ol_done", bus.o_pkt_done, 0);
        check("ol_st_drop", bus.ov_write_state, 2);
        check("ol_req", bus.o_bufid_req, 1);
        wr_word(BD, 129);
        check("ol_rel_pulse", bus.o_bufid_release, 0);
        check("ol_st_drop2", bus.ov_write_state, 2);
        wr_word(TL, 130);
        check("ol_st_idle", bus.ov_write_state, 0);
        check("ol_pkt", bus.ov_pkt_cnt, 0);
        check("ol_relid_hold", bus.ov_release_bufid, 9'h005);

        // missing tail: new head aborts buffer 0x010
        do_reset();
        give_id(9'h010);
        wr_word(HD, 20);
        check("mt_addr0", bus.ov_mem_addr, 16'h0800);
        wr_word(BD, 21);
        check("mt_addr1", bus.ov_mem_addr, 16'h0801);
        wr_word(HD, 22);
        check("mt_nowr", bus.o_mem_wr, 0);
        check("mt_rel", bus.o_bufid_release, 1);
        check("mt_relid", bus.ov_release_bufid, 9'h010);
        check("mt_drop", bus.ov_drop_cnt, 1);
        check("mt_st", bus.ov_write_state, 2);
        wr_word(BD, 23);
        check("mt_nowr2", bus.o_mem_wr, 0);
        wr_word(TL, 24);
        check("mt_nowr3", bus.o_mem_wr, 0);
        check("mt_st_idle", bus.ov_write_state, 0);
        check("mt_drop2", bus.ov_drop_cnt, 1);

        // head+tail aborting an open packet returns to IDLE
        give_id(9'h012);
        wr_word(HD, 25);
        wr_word(HT, 26);
        check("mtht_rel", bus.o_bufid_release, 1);
        check("mtht_relid", bus.ov_release_bufid, 9'h012);
        check("mtht_st", bus.ov_write_state, 0);
        check("mtht_drop", bus.ov_drop_cnt, 2);

        // tail and id delivery in the same cycle
        do_reset();
        give_id(9'h0AB);
        wr_word(HD, 30);
        step(1'b1, pw(TL, 31), 1'b1, 9'h033);
        check("sc_done", bus.o_pkt_done, 1);
        check("sc_dbuf", bus.ov_done_bufid, 9'h0AB);
        check("sc_dlines", bus.ov_done_lines, 2);
        check("sc_req", bus.o_bufid_req, 0);
        wr_word(HT, 32);
        check("sc_ht_addr", bus.ov_mem_addr, 16'h1980);
        check("sc_ht_done", bus.o_pkt_done, 1);
        check("sc_ht_lines", bus.ov_done_lines, 1);
        check("sc_ht_dbuf", bus.ov_done_bufid, 9'h033);
        check("sc_pkt", bus.ov_pkt_cnt, 2);
        check("sc_ht_st", bus.ov_write_state, 0);
        check("sc_req1", bus.o_bufid_req, 1);

        // head with no id and same-cycle delivery: head dropped, id kept
        do_reset();
        step(1'b1, pw(HD, 40), 1'b1, 9'h044);
        check("hd_id_wr", bus.o_mem_wr, 0);
        check("hd_id_drop", bus.ov_drop_cnt, 1);
        check("hd_id_req", bus.o_bufid_req, 0);
        wr_word(TL, 41);
        wr_word(HT, 42);
        check("hd_id_addr", bus.ov_mem_addr, 16'h2200);
        check("hd_id_done", bus.o_pkt_done, 1);

        // second delivery while an id is held is ignored
        give_id(9'h011);
        give_id(9'h022);
        wr_word(HT, 43);
        check("ign_addr", bus.ov_mem_addr, 16'h0880);
        check("ign_dbuf", bus.ov_done_bufid, 9'h011);

        // reset mid-packet
        do_reset();
        give_id(9'h007);
        wr_word(HD, 50);
        wr_word(BD, 51);
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 9'd0);
        check("mr_req", bus.o_bufid_req, 0);
        check("mr_wr", bus.o_mem_wr, 0);
        check("mr_addr", bus.ov_mem_addr, 0);
        check("mr_state", bus.ov_write_state, 0);
        check("mr_dbuf", bus.ov_done_bufid, 0);
        check("mr_rel", bus.o_bufid_release, 0);
        rst = 1'b0;
        wr_word(BD, 52);
        check("mr_req1", bus.o_bufid_req, 1);
        check("mr_nowr", bus.o_mem_wr, 0);
        check("mr_norel", bus.o_bufid_release, 0);
        check("mr_st", bus.ov_write_state, 0);
        wr_word(TL, 53);
        check("mr_nowr2", bus.o_mem_wr, 0);
        check("mr_drop", bus.ov_drop_cnt, 0);
        check("mr_pkt", bus.ov_pkt_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pkt_write_tse.md
PKT_WRITE_TSE -- requirements
Module: pkt_write_tse
Purpose: consumes the 134-bit packet words from the descriptor-extract stage and writes them into the packet buffer under a prefetched buffer id.

Interface
REQ-001 SHALL use one clock and one reset: the reset is synchronous and active-high.
REQ-002 SHALL expose ports (name, direction, width, meaning):
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous active-high reset.
- i_pkt_wr, in, 1: packet word strobe.
- iv_pkt, in, 134: packet word. [133:132] = 01 head, 00 body, 10 tail, 11 head+tail. [131:128] = valid bytes - 1. [127:0] = data.
- o_bufid_req, out, 1: level; the block holds no buffer id.
- i_pkt_bufid_wr, in, 1: buffer id delivery pulse.
- iv_pkt_bufid, in, 9: delivered buffer id.
- o_mem_wr, out, 1: buffer RAM write strobe.
- ov_mem_addr, out, 16: RAM address {bufid[8:0], line[6:0]}.
- ov_mem_data, out, 134: word written to the RAM.
- o_pkt_done, out, 1: packet fully stored.
- ov_done_bufid, out, 9: buffer id of the stored packet.
- ov_done_lines, out, 8: number of lines written, 1..128.
- o_bufid_release, out, 1: abort pulse; the buffer id returns to the free pool.
- ov_release_bufid, out, 9: the released buffer id.
- ov_pkt_cnt, out, 16: stored-packet counter.
- ov_drop_cnt, out, 16: dropped/aborted-packet counter.
- ov_write_state, out, 2: 0 IDLE, 1 WRITE, 2 DROP.

Function
REQ-003 SHALL hold at most one prefetched buffer id in a register with a valid flag. o_bufid_req is registered and equals NOT valid.
REQ-004 SHALL latch iv_pkt_bufid on i_pkt_bufid_wr only when the valid flag is 0. A pulse arriving while valid is 1 SHALL be ignored.
REQ-005 SHALL register all memory-side outputs. o_mem_wr, ov_mem_addr and ov_mem_data appear exactly 1 cycle after the accepted i_pkt_wr. ov_mem_data SHALL equal iv_pkt unchanged.
REQ-006 IDLE, head (01) received with valid=1: write line 0, set line counter to 1, go to WRITE.
REQ-007 IDLE, head+tail (11) received with valid=1: write line 0 and pulse o_pkt_done in the same cycle as o_mem_wr, with ov_done_lines=1. Clear valid, increment ov_pkt_cnt, stay in IDLE.
REQ-008 IDLE, head or head+tail received with valid=0: no write, ov_drop_cnt+1. Head (01) goes to DROP; head+tail (11) stays in IDLE.
REQ-009 IDLE, body or tail word received: ignored silently, no count change.
REQ-010 WRITE, body word received with line counter < 128: write at the current line, then increment the counter.
REQ-011 WRITE, tail received with line counter < 128: write the tail line and pulse o_pkt_done with ov_done_bufid equal to the held id and ov_done_lines equal to the counter + 1. Clear valid, ov_pkt_cnt+1, go to IDLE.
REQ-012 WRITE, any word received with line counter = 128 (overlength): no write.
- Pulse o_bufid_release with the held id 1 cycle later, clear valid, ov_drop_cnt+1.
- Next state is IDLE if that word is a tail, otherwise DROP.
REQ-013 WRITE, head or head+tail received (missing tail):
- Abort the current packet as in REQ-012 and do not write the word.
- Head+tail goes to IDLE; head goes to DROP.
- The new packet SHALL NOT be counted separately.
REQ-014 DROP: discard every word. A tail or head+tail returns to IDLE. No writes and no counts.
REQ-015 SHALL give priority in the same cycle: the packet-completion or abort clearing of valid happens first, and an i_pkt_bufid_wr in that cycle is then latched, so valid remains 1.
REQ-016 SHALL treat i_pkt_bufid_wr in the same cycle as a head received in IDLE with valid=0 as follows: the head is dropped (REQ-008) and the id is latched for the next packet.
REQ-017 SHALL keep o_pkt_done and o_bufid_release as single-cycle pulses that are never asserted together. ov_done_* and ov_release_bufid hold their values between pulses.
REQ-018 SHALL make ov_pkt_cnt and ov_drop_cnt saturate at 0xFFFF.
REQ-019 SHALL ignore i_pkt_wr=0 cycles entirely: no state change and no write.

Reset
REQ-020 SHALL, while i_rst=1, clear every output to 0, including o_bufid_req, and clear the valid flag and line counter. The state SHALL be IDLE and both counters 0.
REQ-021 SHALL register o_bufid_req=1 in the first cycle after i_rst falls.
REQ-022 SHALL, on a reset mid-packet, abandon the packet without a release pulse. Following words go through the IDLE rules (REQ-009).

Verification
REQ-023 Bufid 0x1A2 delivered, then 3-word packet (01,00,10) -> o_mem_wr on 3 cycles at addresses 0xD100, 0xD101, 0xD102. o_pkt_done with ov_done_bufid=0x1A2 and ov_done_lines=3. ov_pkt_cnt=1. o_bufid_req=1 the next cycle.
REQ-024 No bufid held, head+body+tail received -> no o_mem_wr, ov_drop_cnt=1, state sequence IDLE->DROP->IDLE.
REQ-025 Bufid 0x005, head + 128 body words -> 128 writes at lines 0..127. On the 129th word: no write, o_bufid_release with ov_release_bufid=0x005, ov_drop_cnt=1, state DROP until the tail.
REQ-026 Bufid 0x010, head, body, then a new head (01) -> 2 writes, then release of 0x010 and ov_drop_cnt=1. The second packet is discarded through its tail.
REQ-027 Tail received in the same cycle as i_pkt_bufid_wr=0x033 -> o_pkt_done for the old id, 0x033 held, o_bufid_req stays 0. The next head+tail is stored at address 0x1980.
REQ-028 i_rst asserted for 1 cycle mid-packet -> all outputs 0, counters 0, no release pulse. o_bufid_req=1 in the first post-reset cycle, and the remaining body/tail words are ignored.
